bf_sdf_stage_ctrl: RTL and testbench

- Sequencing controller for one radix-2 single-delay-feedback butterfly stage: demux, delay line, add/sub, sub save line, output mux.
- Generates the per-cycle steering and qualification controls from the stage input valid:
  - input demux select
  - output mux select
  - trivial-twiddle (-j) enable
  - output enable
- Tracks each frame on independent input and output phases, so back-to-back frames overlap without bubbles.
- Replaces the ad-hoc counters embedded in each stage; one instance per stage.

---
 rtl/bf_sdf_stage_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_bf_sdf_stage_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bf_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// bf_sdf_stage_ctrl
//   Sequencing controller for one radix-2 single-delay-feedback butterfly
//   stage. From the stage input valid it generates the demux/mux steering,
//   the trivial-twiddle (-j) enable and the output qualification. Input and
//   output phases are tracked independently so consecutive frames overlap
//   without bubbles.
//
//   Ports:
//     clk, rstn    stage clock, asynchronous active-low reset
//     valid_in     input sample valid (contiguous FRAME_LEN cycles per frame)
//     in_sel       demux select for this cycle's sample (0 delay, 1 compute)
//     out_sel      output mux select (0 add result, 1 saved sub result)
//     fac_en       apply -j rotation to the current output sample
//     o_en         stage output valid
//     out_idx      index of the current output sample (0 when o_en=0)
//     busy         input phase running or output phase not idle
//     frame_done   pulse with the last output sample of a frame
//     err_gap      pulse the cycle after valid_in dropped mid-frame
//
//   Optional build macro BFC_FRAME_CNT_EN adds:
//     frame_cnt    16-bit wrapping count of frame_done pulses
//     gap_cnt      8-bit saturating count of err_gap pulses
//
//   Every output is a flop. Controls are computed the cycle before the
//   sample they steer; index 0 needs no look-ahead because the idle value
//   of every select is already 0.
// ---------------------------------------------------------------------------
module bf_sdf_stage_ctrl #(
    parameter int FRAME_LEN  = 32,
    parameter int DELAY      = 2,
    parameter int FAC_PERIOD = 4,
    parameter int FAC_PHASE  = 1,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_in,
    output logic             in_sel,
    output logic             out_sel,
    output logic             fac_en,
    output logic             o_en,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             err_gap
`ifdef BFC_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       gap_cnt
`endif
);

    typedef enum logic {I_IDLE, I_RUN} istate_t;
    typedef enum logic [1:0] {O_IDLE, O_RUN, O_FLUSH} ostate_t;

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_IDX  = CNT_W'(FRAME_LEN - DELAY);
    localparam logic [CNT_W-1:0] LAUNCH_IDX = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] DIV        = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] FAC_P      = CNT_W'(FAC_PERIOD);
    localparam logic [CNT_W-1:0] FAC_PH     = CNT_W'(FAC_PHASE);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    istate_t          istate_q, istate_d;
    ostate_t          ostate_q, ostate_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             in_sel_q, in_sel_d;
    logic             out_sel_q, out_sel_d;
    logic             fac_en_q, fac_en_d;
    logic             o_en_q, o_en_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             err_gap_q, err_gap_d;

    logic             accept, gap, launch, o_run;
    logic [CNT_W-1:0] k, k_nxt, j_nxt;

    always_comb begin
        istate_d     = istate_q;
        in_cnt_d     = in_cnt_q;
        in_sel_d     = 1'b0;
        ostate_d     = O_IDLE;
        out_cnt_d    = '0;
        o_en_d       = 1'b0;
        out_sel_d    = 1'b0;
        fac_en_d     = 1'b0;
        frame_done_d = 1'b0;
        err_gap_d    = 1'b0;
        busy_d       = 1'b0;
        accept       = 1'b0;
        gap          = 1'b0;
        launch       = 1'b0;
        o_run        = 1'b0;
        k            = '0;
        j_nxt        = '0;

        // k is the index of the sample present this cycle
        case (istate_q)
            I_IDLE: accept = valid_in;
            I_RUN: begin
                accept = valid_in;
                gap    = !valid_in;
                k      = in_cnt_q;
            end
            default: ;
        endcase
        k_nxt = k + ONE;

        if (accept) begin
            if (k == LAST_IDX) begin
                istate_d = I_IDLE;
                in_cnt_d = '0;
            end else begin
                istate_d = I_RUN;
                in_cnt_d = k_nxt;
                in_sel_d = ((k_nxt / DIV) & ONE) != '0;
            end
        end

        // Output sample 0 lines up with input sample DELAY, so it is
        // scheduled while input sample DELAY-1 is being accepted. A new
        // launch can only coincide with the last output of the prior frame.
        launch = accept && (k == LAUNCH_IDX);
        if (launch) begin
            o_run = 1'b1;
            j_nxt = '0;
        end else if (ostate_q != O_IDLE && out_cnt_q != LAST_IDX) begin
            o_run = 1'b1;
            j_nxt = out_cnt_q + ONE;
        end

        // A mid-frame drop kills both phases, including a previous frame
        // still flushing underneath.
        if (gap) begin
            istate_d  = I_IDLE;
            in_cnt_d  = '0;
            o_run     = 1'b0;
            err_gap_d = 1'b1;
        end

        if (o_run) begin
            ostate_d     = (j_nxt >= FLUSH_IDX) ? O_FLUSH : O_RUN;
            out_cnt_d    = j_nxt;
            o_en_d       = 1'b1;
            out_sel_d    = ((j_nxt / DIV) & ONE) != '0;
            fac_en_d     = (j_nxt % FAC_P) == FAC_PH;
            frame_done_d = (j_nxt == LAST_IDX);
        end

        busy_d = (istate_d == I_RUN) || o_run;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            istate_q     <= I_IDLE;
            ostate_q     <= O_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            in_sel_q     <= 1'b0;
            out_sel_q    <= 1'b0;
            fac_en_q     <= 1'b0;
            o_en_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_gap_q    <= 1'b0;
        end else begin
            istate_q     <= istate_d;
            ostate_q     <= ostate_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            in_sel_q     <= in_sel_d;
            out_sel_q    <= out_sel_d;
            fac_en_q     <= fac_en_d;
            o_en_q       <= o_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_gap_q    <= err_gap_d;
        end
    end

    assign in_sel     = in_sel_q;
    assign out_sel    = out_sel_q;
    assign fac_en     = fac_en_q;
    assign o_en       = o_en_q;
    assign out_idx    = out_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_gap    = err_gap_q;

`ifdef BFC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + {15'd0, frame_done_q};
        gap_cnt_d   = gap_cnt_q;
        if (err_gap_q && gap_cnt_q != 8'hFF) begin
            gap_cnt_d = gap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign gap_cnt   = gap_cnt_q;
`endif

endmodule

// File: tb/tb_bf_sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bf_sdf_stage_ctrl
//   Directed bench for bf_sdf_stage_ctrl. u0 uses default parameters,
//   u2 uses FRAME_LEN=16, DELAY=4, FAC_PERIOD=8, FAC_PHASE=3.
//   Expected outputs come from closed-form per-cycle formulas of the frame
//   timing: u = cycles since the first valid of a run of nfr frames.
// ---------------------------------------------------------------------------
module tb_bf_sdf_stage_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       valid0, valid2;

    logic       in_sel0, out_sel0, fac_en0, o_en0, busy0, frame_done0, err_gap0;
    logic [6:0] out_idx0;
    logic       in_sel2, out_sel2, fac_en2, o_en2, busy2, frame_done2, err_gap2;
    logic [6:0] out_idx2;
`ifdef BFC_FRAME_CNT_EN
    logic [15:0] frame_cnt0, frame_cnt2;
    logic [7:0]  gap_cnt0, gap_cnt2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bf_sdf_stage_ctrl u0 (
        .clk(clk), .rstn(rstn), .valid_in(valid0),
        .in_sel(in_sel0), .out_sel(out_sel0), .fac_en(fac_en0), .o_en(o_en0),
        .out_idx(out_idx0), .busy(busy0), .frame_done(frame_done0), .err_gap(err_gap0)
`ifdef BFC_FRAME_CNT_EN
        , .frame_cnt(frame_cnt0), .gap_cnt(gap_cnt0)
`endif
    );

    bf_sdf_stage_ctrl #(.FRAME_LEN(16), .DELAY(4), .FAC_PERIOD(8), .FAC_PHASE(3), .CNT_W(7)) u2 (
        .clk(clk), .rstn(rstn), .valid_in(valid2),
        .in_sel(in_sel2), .out_sel(out_sel2), .fac_en(fac_en2), .o_en(o_en2),
        .out_idx(out_idx2), .busy(busy2), .frame_done(frame_done2), .err_gap(err_gap2)
`ifdef BFC_FRAME_CNT_EN
        , .frame_cnt(frame_cnt2), .gap_cnt(gap_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs u cycles after the first valid of nfr back-to-back
    // frames (u < 0 means idle before the run).
    task automatic chk_gen(input string pfx, input int u, input int nfr,
                           input int fl, input int dl, input int fp, input int fph,
                           input logic i_sel, input logic o_sel, input logic fac,
                           input logic oen, input logic [6:0] idx, input logic bsy,
                           input logic fd, input logic gp);
        int   len, j;
        logic e_isel, e_oen, e_osel, e_fac, e_fd, e_busy;
        len    = fl * nfr;
        e_isel = (u >= 0 && u < len) ? (((u / dl) % 2) == 1) : 1'b0;
        e_oen  = (u >= dl) && (u <= len + dl - 1);
        j      = e_oen ? ((u - dl) % fl) : 0;
        e_osel = e_oen && (((j / dl) % 2) == 1);
        e_fac  = e_oen && ((j % fp) == fph);
        e_fd   = e_oen && (j == fl - 1);
        e_busy = (u >= 1) && (u <= len + dl - 1);
        chk($sformatf("%s u=%0d in_sel", pfx, u), 32'(i_sel), 32'(e_isel));
        chk($sformatf("%s u=%0d o_en", pfx, u), 32'(oen), 32'(e_oen));
        chk($sformatf("%s u=%0d out_idx", pfx, u), 32'(idx), 32'(j));
        chk($sformatf("%s u=%0d out_sel", pfx, u), 32'(o_sel), 32'(e_osel));
        chk($sformatf("%s u=%0d fac_en", pfx, u), 32'(fac), 32'(e_fac));
        chk($sformatf("%s u=%0d frame_done", pfx, u), 32'(fd), 32'(e_fd));
        chk($sformatf("%s u=%0d busy", pfx, u), 32'(bsy), 32'(e_busy));
        chk($sformatf("%s u=%0d err_gap", pfx, u), 32'(gp), 32'd0);
    endtask

    task automatic chk_u0(input string pfx, input int u, input int nfr);
        chk_gen(pfx, u, nfr, 32, 2, 4, 1, in_sel0, out_sel0, fac_en0, o_en0,
                out_idx0, busy0, frame_done0, err_gap0);
    endtask

    task automatic chk_u2(input string pfx, input int u, input int nfr);
        chk_gen(pfx, u, nfr, 16, 4, 8, 3, in_sel2, out_sel2, fac_en2, o_en2,
                out_idx2, busy2, frame_done2, err_gap2);
    endtask

    initial begin
        rstn   = 1'b0;
        valid0 = 1'b0;
        valid2 = 1'b0;

        // reset state
        #12;
        chk_u0("reset", -10, 1);
        chk_u2("reset2", -10, 1);
`ifdef BFC_FRAME_CNT_EN
        chk("reset frame_cnt", 32'(frame_cnt0), 32'd0);
        chk("reset gap_cnt", 32'(gap_cnt0), 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk_u0("idle", -1, 1);
        tick();

        // single frame
        for (int t = 0; t < 38; t++) begin
            valid0 = (t < 32);
            chk_u0("single", t, 1);
            tick();
        end

        // two frames back to back
        for (int t = 0; t < 70; t++) begin
            valid0 = (t < 64);
            chk_u0("b2b", t, 2);
            tick();
        end

        // gap at sample 10, restart at cycle 12
        for (int t = 0; t < 50; t++) begin
            valid0 = (t < 10) || (t >= 12 && t < 44);
            if (t <= 10) begin
                chk_u0("gap", t, 1);
            end else if (t == 11) begin
                chk("gap t=11 err_gap", 32'(err_gap0), 32'd1);
                chk("gap t=11 o_en", 32'(o_en0), 32'd0);
                chk("gap t=11 in_sel", 32'(in_sel0), 32'd0);
                chk("gap t=11 out_sel", 32'(out_sel0), 32'd0);
                chk("gap t=11 fac_en", 32'(fac_en0), 32'd0);
                chk("gap t=11 out_idx", 32'(out_idx0), 32'd0);
                chk("gap t=11 frame_done", 32'(frame_done0), 32'd0);
                chk("gap t=11 busy", 32'(busy0), 32'd0);
            end else begin
                chk_u0("restart", t - 12, 1);
            end
            tick();
        end
`ifdef BFC_FRAME_CNT_EN
        chk("frame_cnt", 32'(frame_cnt0), 32'd4);
        chk("gap_cnt", 32'(gap_cnt0), 32'd1);
`endif

        // reset mid-frame at cycle 15
        for (int t = 0; t < 16; t++) begin
            valid0 = 1'b1;
            chk_u0("pre-rst", t, 1);
            if (t < 15) tick();
        end
        rstn = 1'b0;
        #2;
        chk_u0("async-rst", -10, 1);
        valid0 = 1'b0;
        tick();
        @(negedge clk);
        rstn = 1'b1;
        tick();
`ifdef BFC_FRAME_CNT_EN
        chk("post-rst frame_cnt", 32'(frame_cnt0), 32'd0);
        chk("post-rst gap_cnt", 32'(gap_cnt0), 32'd0);
`endif
        for (int t = 0; t < 38; t++) begin
            valid0 = (t < 32);
            chk_u0("post-rst", t, 1);
            tick();
        end

        // parameter sweep instance
        for (int t = 0; t < 24; t++) begin
            valid2 = (t < 16);
            chk_u2("sweep", t, 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
